// File: rtl/ro_pkg.sv
// Shared definitions for the readout event packer: word tags, field positions,
// counter widths, FSM state encoding and word-building helpers.
package ro_pkg;

  localparam int EVT_W   = 12;
  localparam int IDX_W   = 14;
  localparam int WCNT_W  = 11;
  localparam int FIELD_W = 16;

  localparam logic [3:0] HDR_TAG  = 4'hA;
  localparam logic [1:0] DATA_TAG = 2'b01;
  localparam logic [3:0] TRL_TAG  = 4'hE;

  localparam int TAG_LSB      = 28;
  localparam int DATA_TAG_LSB = 30;
  localparam int EVT_LSB      = 16;
  localparam int IDX_LSB      = 16;
  localparam int TRUNC_BIT    = 27;
  localparam int WCNT_LSB     = 16;

  localparam logic [EVT_W-1:0]  EVT_ONE  = {{(EVT_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [WCNT_W-1:0] WCNT_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};
  localparam logic [WCNT_W-1:0] WCNT_MAX = {WCNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_TRL  = 2'd3
  } state_t;

  function automatic logic [31:0] mk_header(input logic [EVT_W-1:0] evt,
                                            input logic [FIELD_W-1:0] ts);
    logic [31:0] w;
    w = '0;
    w[TAG_LSB +: 4]     = HDR_TAG;
    w[EVT_LSB +: EVT_W] = evt;
    w[0 +: FIELD_W]     = ts;
    return w;
  endfunction

  function automatic logic [31:0] mk_data(input logic [IDX_W-1:0] idx,
                                          input logic [FIELD_W-1:0] sample);
    logic [31:0] w;
    w = '0;
    w[DATA_TAG_LSB +: 2] = DATA_TAG;
    w[IDX_LSB +: IDX_W]  = idx;
    w[0 +: FIELD_W]      = sample;
    return w;
  endfunction

  function automatic logic [31:0] mk_trailer(input logic trunc,
                                             input logic [WCNT_W-1:0] wcnt,
                                             input logic [FIELD_W-1:0] sum);
    logic [31:0] w;
    w = '0;
    w[TAG_LSB +: 4]       = TRL_TAG;
    w[TRUNC_BIT]          = trunc;
    w[WCNT_LSB +: WCNT_W] = wcnt;
    w[0 +: FIELD_W]       = sum;
    return w;
  endfunction

endpackage

// File: rtl/ro_sync_fifo.sv
// 32-bit synchronous FIFO with registered read data and registered FULL/EMPTY
// flags derived from an occupancy counter one bit wider than the pointers.
module ro_sync_fifo #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] din,
  input  logic        rd_en,
  output logic [31:0] dout,
  output logic        empty,
  output logic        full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic [31:0]           dout_q;
  logic                  wr_ok, rd_ok;

  // Flags are registered, so accept/pop decisions use the previous-cycle view.
  assign wr_ok = wr_en & ~full_q;
  assign rd_ok = rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      if (rd_ok) dout_q <= mem[rd_ptr_q];
    end
  end

  assign dout  = dout_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/ro_event_packer.sv
// Frames sequencer strobes into header/data/trailer words and buffers them in a FIFO.
// Optional trailer checksum is enabled by defining RO_CHECKSUM_EN.
module ro_event_packer
  import ro_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int ADC_W      = 14,
  parameter int TS_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WR_EN,
  input  logic             CHSEL,
  input  logic [ADC_W-1:0] ADC_DATA,
  input  logic             RD_EN,
  output logic [31:0]      DOUT,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVERFLOW,
  output logic             PROTO_ERR,
  output logic [11:0]      EVT_CNT
);

  localparam logic [TS_W-1:0] TS_ONE = {{(TS_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [EVT_W-1:0]    evt_q, evt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                trunc_q, trunc_d;
  logic [31:0]         word_q, word_d;
  logic                word_vld_q, word_vld_d;
  logic                ovf_q, ovf_d;
  logic                perr_q, perr_d;

  logic [FIELD_W-1:0]  ts16;
  logic [FIELD_W-1:0]  adc16;
  logic [FIELD_W-1:0]  trl_sum;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drop_now;
  state_t              eff_state;
  logic [EVT_W-1:0]    evt_hdr;
  logic                do_hdr, do_data, do_trl;

  generate
    if (TS_W >= FIELD_W) begin : g_ts_wide
      assign ts16 = ts_q[FIELD_W-1:0];
    end else begin : g_ts_narrow
      assign ts16 = {{(FIELD_W-TS_W){1'b0}}, ts_q};
    end
    if (ADC_W >= FIELD_W) begin : g_adc_full
      assign adc16 = ADC_DATA[FIELD_W-1:0];
    end else begin : g_adc_ext
      assign adc16 = {{(FIELD_W-ADC_W){1'b0}}, ADC_DATA};
    end
  endgenerate

  // The word registered last edge is written (or dropped) at this edge.
  assign drop_now = word_vld_q & fifo_full;

`ifdef RO_CHECKSUM_EN
  logic [FIELD_W-1:0] csum_q, csum_d;
  assign trl_sum = csum_q;
`else
  assign trl_sum = '0;
`endif

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q + TS_ONE;
    evt_d      = evt_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    trunc_d    = trunc_q | drop_now;
    word_d     = word_q;
    word_vld_d = 1'b0;
    ovf_d      = ovf_q | drop_now;
    perr_d     = perr_q;
    eff_state  = state_q;
    evt_hdr    = evt_q;
    do_hdr     = 1'b0;
    do_data    = 1'b0;
    do_trl     = 1'b0;
`ifdef RO_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    // TRL closes the event and then behaves as IDLE within the same cycle.
    if (state_q == ST_TRL) begin
      evt_d     = evt_q + EVT_ONE;
      evt_hdr   = evt_q + EVT_ONE;
      eff_state = ST_IDLE;
      state_d   = ST_IDLE;
    end

    case (eff_state)
      ST_IDLE: begin
        if (WR_EN && CHSEL)  perr_d = 1'b1;
        else if (WR_EN)      do_hdr = 1'b1;
      end
      ST_HDR: begin
        if (WR_EN && CHSEL) begin
          do_data = 1'b1;
        end else if (WR_EN) begin
          do_hdr = 1'b1;
          perr_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (!WR_EN) begin
          do_trl = 1'b1;
        end else if (CHSEL) begin
          do_data = 1'b1;
        end else begin
          do_hdr = 1'b1;
          perr_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (do_hdr) begin
      state_d    = ST_HDR;
      word_d     = mk_header(evt_hdr, ts16);
      word_vld_d = 1'b1;
      idx_d      = '0;
      wcnt_d     = '0;
      trunc_d    = 1'b0;
`ifdef RO_CHECKSUM_EN
      csum_d     = ts16;
`endif
    end

    if (do_data) begin
      state_d    = ST_DATA;
      word_d     = mk_data(idx_q, adc16);
      word_vld_d = 1'b1;
      idx_d      = idx_q + IDX_ONE;
      wcnt_d     = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + WCNT_ONE;
`ifdef RO_CHECKSUM_EN
      csum_d     = csum_q ^ adc16;
`endif
    end

    // Truncation must include a drop of the last data word happening right now.
    if (do_trl) begin
      state_d    = ST_TRL;
      word_d     = mk_trailer(trunc_q | drop_now, wcnt_q, trl_sum);
      word_vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      ts_q       <= '0;
      evt_q      <= '0;
      idx_q      <= '0;
      wcnt_q     <= '0;
      trunc_q    <= 1'b0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      evt_q      <= evt_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      trunc_q    <= trunc_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
      ovf_q      <= ovf_d;
      perr_q     <= perr_d;
    end
  end

`ifdef RO_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

  ro_sync_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .wr_en (word_vld_q),
    .din   (word_q),
    .rd_en (RD_EN),
    .dout  (DOUT),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign EMPTY     = fifo_empty;
  assign FULL      = fifo_full;
  assign OVERFLOW  = ovf_q;
  assign PROTO_ERR = perr_q;
  assign EVT_CNT   = evt_q;

endmodule

// File: tb/tb_ro_event_packer.sv
// Directed bench for ro_event_packer: table-driven single event plus hand-written
// protocol, overflow, wrap/concurrency and async-reset sequences.
module tb_ro_event_packer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        WR_EN = 1'b0;
  logic        CHSEL = 1'b0;
  logic [13:0] ADC_DATA = '0;
  logic        RD_EN = 1'b0;
  logic [31:0] DOUT;
  logic        EMPTY, FULL, OVERFLOW, PROTO_ERR;
  logic [11:0] EVT_CNT;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] ts_model;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic        ch;
    logic [13:0] adc;
    logic        rd;
    logic        chk_dout;
    logic [31:0] exp_dout;
    logic        exp_empty;
    logic [11:0] exp_evt;
  } vec_t;

  vec_t tbl[12];

  ro_event_packer #(
    .DEPTH_LOG2(3),
    .ADC_W(14),
    .TS_W(16)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .CHSEL(CHSEL), .ADC_DATA(ADC_DATA),
    .RD_EN(RD_EN), .DOUT(DOUT), .EMPTY(EMPTY), .FULL(FULL), .OVERFLOW(OVERFLOW),
    .PROTO_ERR(PROTO_ERR), .EVT_CNT(EVT_CNT)
  );

  always #5 CLK = ~CLK;

  // Reference timestamp: same reset and increment rule as the design's counter.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ts_model <= '0;
    else        ts_model <= ts_model + 16'd1;
  end

  function automatic vec_t mkv(input logic wr, input logic ch, input logic [13:0] adc,
                               input logic rd, input logic chk, input logic [31:0] d,
                               input logic e, input logic [11:0] evt);
    vec_t v;
    v.wr = wr; v.ch = ch; v.adc = adc; v.rd = rd;
    v.chk_dout = chk; v.exp_dout = d; v.exp_empty = e; v.exp_evt = evt;
    return v;
  endfunction

  function automatic logic [31:0] hdr_w(input logic [11:0] evt, input logic [15:0] ts);
    return {4'hA, evt, ts};
  endfunction

  function automatic logic [31:0] data_w(input logic [13:0] idx, input logic [13:0] adc);
    return {2'b01, idx, 2'b00, adc};
  endfunction

  function automatic logic [31:0] trl_w(input logic tr, input logic [10:0] cnt);
    return {4'hE, tr, cnt, 16'h0000};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic wr, input logic ch, input logic [13:0] adc, input logic rd);
    WR_EN = wr; CHSEL = ch; ADC_DATA = adc; RD_EN = rd;
    @(negedge CLK);
  endtask

  task automatic pop_check(input string name, input logic [31:0] exp);
    cyc(1'b0, 1'b0, 14'd0, 1'b1);
    RD_EN = 1'b0;
    check(name, DOUT, exp);
  endtask

  task automatic do_reset;
    WR_EN = 1'b0; CHSEL = 1'b0; ADC_DATA = '0; RD_EN = 1'b0;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // One cycle with RD_EN high; pops are scored against the expected-word queue.
  task automatic step_sb(input logic wr, input logic ch, input logic [13:0] adc,
                         input logic push, input logic [31:0] w);
    logic pop;
    pop = !EMPTY;
    WR_EN = wr; CHSEL = ch; ADC_DATA = adc; RD_EN = 1'b1;
    if (push) exp_q.push_back(w);
    @(negedge CLK);
    if (pop) begin
      if (exp_q.size() == 0) check("wrap_extra_pop", 32'd1, 32'd0);
      else                   check("wrap_dout", DOUT, exp_q.pop_front());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] t_a, t_b;

    tbl[0]  = mkv(1'b1, 1'b0, 14'h00,  1'b0, 1'b0, 32'h0,        1'b1, 12'd0);
    tbl[1]  = mkv(1'b1, 1'b1, 14'h11,  1'b0, 1'b0, 32'h0,        1'b0, 12'd0);
    tbl[2]  = mkv(1'b1, 1'b1, 14'h22,  1'b0, 1'b0, 32'h0,        1'b0, 12'd0);
    tbl[3]  = mkv(1'b1, 1'b1, 14'h33,  1'b0, 1'b0, 32'h0,        1'b0, 12'd0);
    tbl[4]  = mkv(1'b0, 1'b0, 14'h00,  1'b0, 1'b0, 32'h0,        1'b0, 12'd0);
    tbl[5]  = mkv(1'b0, 1'b0, 14'h00,  1'b0, 1'b0, 32'h0,        1'b0, 12'd1);
    tbl[6]  = mkv(1'b0, 1'b0, 14'h00,  1'b1, 1'b1, 32'hA0000005, 1'b0, 12'd1);
    tbl[7]  = mkv(1'b0, 1'b0, 14'h00,  1'b1, 1'b1, 32'h40000011, 1'b0, 12'd1);
    tbl[8]  = mkv(1'b0, 1'b0, 14'h00,  1'b1, 1'b1, 32'h40010022, 1'b0, 12'd1);
    tbl[9]  = mkv(1'b0, 1'b0, 14'h00,  1'b1, 1'b1, 32'h40020033, 1'b0, 12'd1);
    tbl[10] = mkv(1'b0, 1'b0, 14'h00,  1'b1, 1'b1, 32'hE0030000, 1'b1, 12'd1);
    tbl[11] = mkv(1'b0, 1'b0, 14'h00,  1'b1, 1'b1, 32'hE0030000, 1'b1, 12'd1);

    // Reset state
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_dout", DOUT, 32'd0);
    check("rst_overflow", 32'(OVERFLOW), 32'd0);
    check("rst_proto_err", 32'(PROTO_ERR), 32'd0);
    check("rst_evt_cnt", 32'(EVT_CNT), 32'd0);

    // Single event: header strobe sampled while the timestamp is 5
    repeat (5) @(negedge CLK);
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].wr, tbl[i].ch, tbl[i].adc, tbl[i].rd);
      check($sformatf("evt1_empty[%0d]", i), 32'(EMPTY), 32'(tbl[i].exp_empty));
      check($sformatf("evt1_evt_cnt[%0d]", i), 32'(EVT_CNT), 32'(tbl[i].exp_evt));
      check($sformatf("evt1_proto[%0d]", i), 32'(PROTO_ERR), 32'd0);
      if (tbl[i].chk_dout) check($sformatf("evt1_dout[%0d]", i), DOUT, tbl[i].exp_dout);
    end

    // Protocol error (a): data strobe in IDLE is dropped
    cyc(1'b1, 1'b1, 14'h7, 1'b0);
    cyc(1'b0, 1'b0, 14'h0, 1'b0);
    cyc(1'b0, 1'b0, 14'h0, 1'b0);
    check("perr_a_flag", 32'(PROTO_ERR), 32'd1);
    check("perr_a_empty", 32'(EMPTY), 32'd1);
    check("perr_a_evt_cnt", 32'(EVT_CNT), 32'd1);

    // Protocol error (b): header right after data, no idle gap
    do_reset();
    check("perr_b_rst_flag", 32'(PROTO_ERR), 32'd0);
    t_a = ts_model;
    cyc(1'b1, 1'b0, 14'h0, 1'b0);
    cyc(1'b1, 1'b1, 14'h44, 1'b0);
    check("perr_b_before", 32'(PROTO_ERR), 32'd0);
    t_b = ts_model;
    cyc(1'b1, 1'b0, 14'h0, 1'b0);
    check("perr_b_flag", 32'(PROTO_ERR), 32'd1);
    cyc(1'b1, 1'b1, 14'h55, 1'b0);
    cyc(1'b0, 1'b0, 14'h0, 1'b0);
    cyc(1'b0, 1'b0, 14'h0, 1'b0);
    check("perr_b_evt_cnt", 32'(EVT_CNT), 32'd1);
    pop_check("perr_b_hdr1", hdr_w(12'd0, t_a));
    pop_check("perr_b_data1", data_w(14'd0, 14'h44));
    pop_check("perr_b_hdr2", hdr_w(12'd0, t_b));
    pop_check("perr_b_data2", data_w(14'd0, 14'h55));
    pop_check("perr_b_trl", trl_w(1'b0, 11'd1));
    check("perr_b_empty", 32'(EMPTY), 32'd1);

    // Overflow: header + 10 data into an 8-deep FIFO with no reads
    do_reset();
    t_a = ts_model;
    cyc(1'b1, 1'b0, 14'h0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 14'(i + 1), 1'b0);
    cyc(1'b0, 1'b0, 14'h0, 1'b0);
    cyc(1'b0, 1'b0, 14'h0, 1'b0);
    check("ovf_full", 32'(FULL), 32'd1);
    check("ovf_flag", 32'(OVERFLOW), 32'd1);
    check("ovf_evt_cnt", 32'(EVT_CNT), 32'd1);
    check("ovf_proto", 32'(PROTO_ERR), 32'd0);
    pop_check("ovf_hdr", hdr_w(12'd0, t_a));
    check("ovf_full_after_pop", 32'(FULL), 32'd0);
    for (int i = 0; i < 7; i++) pop_check($sformatf("ovf_data[%0d]", i), data_w(14'(i), 14'(i + 1)));
    check("ovf_empty_after", 32'(EMPTY), 32'd1);
    check("ovf_sticky", 32'(OVERFLOW), 32'd1);

    // Wrap and concurrency: 4097 minimal events with RD_EN held high
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 4097; k++) begin
      step_sb(1'b1, 1'b0, 14'h0, 1'b1, hdr_w(12'(k), ts_model));
      step_sb(1'b1, 1'b1, 14'(k), 1'b1, data_w(14'd0, 14'(k)));
      step_sb(1'b0, 1'b0, 14'h0, 1'b1, trl_w(1'b0, 11'd1));
      check("wrap_full", 32'(FULL), 32'd0);
    end
    repeat (4) step_sb(1'b0, 1'b0, 14'h0, 1'b0, 32'd0);
    RD_EN = 1'b0;
    check("wrap_evt_cnt", 32'(EVT_CNT), 32'd1);
    check("wrap_overflow", 32'(OVERFLOW), 32'd0);
    check("wrap_proto", 32'(PROTO_ERR), 32'd0);
    check("wrap_empty", 32'(EMPTY), 32'd1);
    check("wrap_all_read", 32'(exp_q.size()), 32'd0);

    // Async reset in the middle of DATA
    cyc(1'b1, 1'b0, 14'h0, 1'b0);
    cyc(1'b1, 1'b1, 14'h1, 1'b0);
    cyc(1'b1, 1'b1, 14'h2, 1'b0);
    check("areset_pre_empty", 32'(EMPTY), 32'd0);
    WR_EN = 1'b0; CHSEL = 1'b0; ADC_DATA = '0;
    #2 RST_N = 1'b0;
    #1;
    check("areset_empty", 32'(EMPTY), 32'd1);
    check("areset_dout", DOUT, 32'd0);
    check("areset_evt_cnt", 32'(EVT_CNT), 32'd0);
    check("areset_full", 32'(FULL), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    t_a = ts_model;
    cyc(1'b1, 1'b0, 14'h0, 1'b0);
    cyc(1'b1, 1'b1, 14'h9, 1'b0);
    cyc(1'b0, 1'b0, 14'h0, 1'b0);
    cyc(1'b0, 1'b0, 14'h0, 1'b0);
    pop_check("areset_hdr", hdr_w(12'd0, t_a));
    pop_check("areset_data", data_w(14'd0, 14'h9));
    pop_check("areset_trl", trl_w(1'b0, 11'd1));
    check("areset_evt_after", 32'(EVT_CNT), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
